// File: rtl/standoff_referee_if.sv
// Round control and result bus between the debounced buttons, the referee and the display logic.
interface standoff_referee_if;
    logic        start;
    logic        p0_btn;
    logic        p1_btn;
    logic        draw_led;
    logic        busy;
    logic [1:0]  winner;
    logic        foul;
    logic [15:0] reaction_ms;

    modport master (
        output start, p0_btn, p1_btn,
        input  draw_led, busy, winner, foul, reaction_ms
    );

    modport slave (
        input  start, p0_btn, p1_btn,
        output draw_led, busy, winner, foul, reaction_ms
    );
endinterface

// File: rtl/standoff_referee.sv
// Two-player standoff referee: random pre-draw delay, foul detection, first-press winner and reaction time in ms.
module standoff_referee #(
    parameter int unsigned TICK_DIV       = 100000,
    parameter int unsigned MIN_WAIT_MS    = 1000,
    parameter int unsigned WAIT_SPAN_LOG2 = 11,
    parameter int unsigned TIMEOUT_MS     = 5000,
    parameter int unsigned RESULT_MS      = 3000
) (
    input logic               clk,
    input logic               rst_n,
    standoff_referee_if.slave bus
);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_DRAW, S_RESULT} state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
    logic [15:0]        ms_cnt_q, ms_cnt_d;
    logic               p0_q, p1_q;
    logic               draw_led_q, draw_led_d;
    logic               busy_q, busy_d;
    logic               foul_q, foul_d;
    logic [1:0]         winner_q, winner_d;
    logic [15:0]        reaction_q, reaction_d;
    logic               tick, p0_rise, p1_rise, any_rise;

    assign tick     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign p0_rise  = bus.p0_btn & ~p0_q;
    assign p1_rise  = bus.p1_btn & ~p1_q;
    assign any_rise = p0_rise | p1_rise;
    assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // Restarting the tick phase on each state change keeps every interval an exact multiple of TICK_DIV.
    assign tick_cnt_d = ((state_d != state_q) || tick) ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ms_cnt_d   = ms_cnt_q;
        winner_d   = winner_q;
        foul_d     = foul_q;
        reaction_d = reaction_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    winner_d   = '0;
                    foul_d     = 1'b0;
                    reaction_d = '0;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                if (!bus.p0_btn && !bus.p1_btn) begin
                    wait_cnt_d = 16'(MIN_WAIT_MS) + 16'(lfsr_q[WAIT_SPAN_LOG2-1:0]);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A press on the would-be draw cycle still counts as a foul.
                if (any_rise) begin
                    foul_d     = 1'b1;
                    winner_d   = (p0_rise && p1_rise) ? 2'b00 : (p0_rise ? 2'b10 : 2'b01);
                    wait_cnt_d = 16'(RESULT_MS);
                    state_d    = S_RESULT;
                end else if (tick) begin
                    if (wait_cnt_q == 16'd1) begin
                        ms_cnt_d = '0;
                        state_d  = S_DRAW;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
            end
            S_DRAW: begin
                if (any_rise) begin
                    winner_d   = {p1_rise, p0_rise};
                    reaction_d = ms_cnt_q;
                    foul_d     = 1'b0;
                    wait_cnt_d = 16'(RESULT_MS);
                    state_d    = S_RESULT;
                end else if (tick) begin
                    if (ms_cnt_q >= 16'(TIMEOUT_MS - 1)) begin
                        winner_d   = 2'b00;
                        reaction_d = (TIMEOUT_MS > 65535) ? '1 : 16'(TIMEOUT_MS);
                        wait_cnt_d = 16'(RESULT_MS);
                        state_d    = S_RESULT;
                    end else if (ms_cnt_q != '1) begin
                        ms_cnt_d = ms_cnt_q + 1'b1;
                    end
                end
            end
            S_RESULT: begin
                if (tick) begin
                    if (wait_cnt_q == 16'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        draw_led_d = (state_d == S_DRAW);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 16'hACE1;
            tick_cnt_q <= '0;
            wait_cnt_q <= '0;
            ms_cnt_q   <= '0;
            p0_q       <= 1'b0;
            p1_q       <= 1'b0;
            draw_led_q <= 1'b0;
            busy_q     <= 1'b0;
            foul_q     <= 1'b0;
            winner_q   <= '0;
            reaction_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            tick_cnt_q <= tick_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            p0_q       <= bus.p0_btn;
            p1_q       <= bus.p1_btn;
            draw_led_q <= draw_led_d;
            busy_q     <= busy_d;
            foul_q     <= foul_d;
            winner_q   <= winner_d;
            reaction_q <= reaction_d;
        end
    end

    assign bus.draw_led    = draw_led_q;
    assign bus.busy        = busy_q;
    assign bus.foul        = foul_q;
    assign bus.winner      = winner_q;
    assign bus.reaction_ms = reaction_q;
endmodule

// File: tb/tb_standoff_referee.sv
// Directed and randomized rounds for standoff_referee, checked against a timing model derived from the game rules.
module tb_standoff_referee;
    localparam int unsigned TICK_DIV       = 4;
    localparam int unsigned MIN_WAIT_MS    = 2;
    localparam int unsigned WAIT_SPAN_LOG2 = 2;
    localparam int unsigned TIMEOUT_MS     = 10;
    localparam int unsigned RESULT_MS      = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [1:0]  e_win  = 2'b00;
    logic        e_foul = 1'b0;
    logic [15:0] e_react = 16'd0;

    standoff_referee_if bus ();

    standoff_referee #(
        .TICK_DIV       (TICK_DIV),
        .MIN_WAIT_MS    (MIN_WAIT_MS),
        .WAIT_SPAN_LOG2 (WAIT_SPAN_LOG2),
        .TIMEOUT_MS     (TIMEOUT_MS),
        .RESULT_MS      (RESULT_MS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // One clock edge; the model LFSR follows the free-running sequence, then outputs settle for sampling.
    task automatic step();
        @(posedge clk);
        if (!rst_n) m_lfsr = 16'hACE1;
        else        m_lfsr = lfsr_step(m_lfsr);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_draw, input logic e_busy);
        chk({tag, "_draw"},   16'(bus.draw_led), 16'(e_draw));
        chk({tag, "_busy"},   16'(bus.busy),     16'(e_busy));
        chk({tag, "_winner"}, 16'(bus.winner),   16'(e_win));
        chk({tag, "_foul"},   16'(bus.foul),     16'(e_foul));
        chk({tag, "_react"},  bus.reaction_ms,   e_react);
    endtask

    // kind: 0 foul in WAIT at wpos_in, 1 press in DRAW at dpos_in, 2 timeout, 3 reset mid-DRAW at dpos_in.
    // Zero positions are randomized; wstart/rstart pulse start during WAIT/RESULT when nonzero.
    task automatic play(input bit hold, input int kind, input logic [1:0] mask,
                        input int wpos_in, input int dpos_in, input int wstart, input int rstart);
        int  w_ms, wpos, dpos, wait_len, draw_len;
        bit  done;
        bus.p0_btn = hold;
        bus.p1_btn = 1'b0;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        e_win = 2'b00; e_foul = 1'b0; e_react = 16'd0;
        chk_out("arm", 1'b0, 1'b1);
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk_out("arm_hold", 1'b0, 1'b1);
            end
            bus.p0_btn = 1'b0;
        end
        w_ms     = int'(MIN_WAIT_MS) + (int'(m_lfsr) % (1 << WAIT_SPAN_LOG2));
        wait_len = int'(TICK_DIV) * w_ms;
        draw_len = int'(TICK_DIV * TIMEOUT_MS);
        step();
        chk_out("wait_entry", 1'b0, 1'b1);

        wpos = wpos_in;
        if (wpos == 0) wpos = int'($urandom_range(1, wait_len));
        if (wpos > wait_len) wpos = wait_len;
        done = 1'b0;
        for (int s = 1; s <= wait_len && !done; s++) begin
            bus.start = (s == wstart);
            if (kind == 0 && s == wpos) begin
                bus.p0_btn = mask[0];
                bus.p1_btn = mask[1];
            end
            step();
            bus.start = 1'b0;
            if (kind == 0 && s == wpos) begin
                e_foul = 1'b1;
                e_win  = (mask == 2'b11) ? 2'b00 : {mask[0], mask[1]};
                chk_out("foul", 1'b0, 1'b1);
                done = 1'b1;
            end else begin
                chk_out("wait", (s == wait_len), 1'b1);
            end
        end

        dpos = dpos_in;
        if (dpos == 0) dpos = int'($urandom_range(1, draw_len));
        for (int s = 1; s <= draw_len && !done; s++) begin
            if (kind == 3 && s == dpos) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                e_win = 2'b00; e_foul = 1'b0; e_react = 16'd0;
                chk_out("mid_reset", 1'b0, 1'b0);
                return;
            end
            if (kind == 1 && s == dpos) begin
                bus.p0_btn = mask[0];
                bus.p1_btn = mask[1];
            end
            step();
            if (kind == 1 && s == dpos) begin
                e_win   = mask;
                e_react = 16'((s - 1) / int'(TICK_DIV));
                chk_out("press", 1'b0, 1'b1);
                done = 1'b1;
            end else if (s == draw_len) begin
                e_win   = 2'b00;
                e_react = 16'(TIMEOUT_MS);
                chk_out("timeout", 1'b0, 1'b1);
                done = 1'b1;
            end else begin
                chk_out("draw", 1'b1, 1'b1);
            end
        end

        bus.p0_btn = 1'b0;
        bus.p1_btn = 1'b0;
        for (int s = 1; s <= int'(TICK_DIV * RESULT_MS); s++) begin
            bus.start  = (s == rstart);
            bus.p1_btn = (rstart != 0 && s == rstart + 2);
            step();
            chk_out("result", 1'b0, (s < int'(TICK_DIV * RESULT_MS)));
        end
        bus.start  = 1'b0;
        bus.p1_btn = 1'b0;
        step();
        chk_out("idle", 1'b0, 1'b0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.p0_btn = 1'b0;
        bus.p1_btn = 1'b0;
        step();
        chk_out("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("reset_idle", 1'b0, 1'b0);

        play(1'b0, 1, 2'b10, 0, 21, 2, 5);
        play(1'b0, 0, 2'b01, 0, 0, 0, 0);
        play(1'b0, 0, 2'b11, 1000, 0, 0, 0);
        play(1'b0, 0, 2'b10, 1, 0, 0, 0);
        play(1'b0, 1, 2'b11, 0, 0, 0, 0);
        play(1'b0, 2, 2'b00, 0, 0, 0, 0);
        play(1'b1, 1, 2'b01, 0, 0, 0, 0);
        play(1'b0, 1, 2'b01, 0, int'(TICK_DIV * TIMEOUT_MS), 0, 0);
        play(1'b0, 1, 2'b10, 0, 1, 0, 0);

        for (int r = 0; r < 12; r++) begin
            play(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 2'($urandom_range(1, 3)),
                 0, 0, int'($urandom_range(0, 6)), int'($urandom_range(0, 10)));
        end

        play(1'b0, 3, 2'b00, 0, 0, 0, 0);
        play(1'b0, 1, 2'b01, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
